// File: rtl/cpu.sv
// Single-cycle 8-bit Harvard CPU: combinational fetch/decode/execute with
// PC, register file and data memory committing together on each rising edge.

module cpu_prog_mem (
   input  logic        clk,
   input  logic        we,
   input  logic [7:0]  waddr,
   input  logic [15:0] wdata,
   input  logic [7:0]  addr,
   output logic [15:0] data
);
   logic [15:0] memory [0:255];

   // Write port exists only so the array is a real storage element; the core ties it off.
   always_ff @(posedge clk) begin
      if (we) memory[waddr] <= wdata;
   end

   assign data = memory[addr];
endmodule

module cpu_reg_file (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [2:0] waddr,
   input  logic [7:0] wdata,
   input  logic [2:0] ra1,
   input  logic [2:0] ra2,
   input  logic [2:0] ra3,
   output logic [7:0] rd1,
   output logic [7:0] rd2,
   output logic [7:0] rd3
);
   logic [7:0] register_tab [0:7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) register_tab[i] <= 8'd0;
      end else if (we) begin
         register_tab[waddr] <= wdata;
      end
   end

   assign rd1 = register_tab[ra1];
   assign rd2 = register_tab[ra2];
   assign rd3 = register_tab[ra3];
endmodule

module cpu_data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);
   logic [7:0] mem [0:255];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

module cpu (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] pc_out,
   output logic [15:0] current_instruction,
   output logic [7:0]  alu_result_out
);
   logic [15:0] pc;
   logic [15:0] pc_next;
   logic [15:0] instr;
   logic [3:0]  op;
   logic [2:0]  rd;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic [7:0]  off6;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  rd_val;
   logic [7:0]  mem_rdata;
   logic [7:0]  alu_result;
   logic [7:0]  wb_data;
   logic        reg_we;
   logic        mem_read;
   logic        mem_write;

   cpu_prog_mem prog_mem (
      .clk   (clk),
      .we    (1'b0),
      .waddr (8'd0),
      .wdata (16'd0),
      .addr  (pc[7:0]),
      .data  (instr)
   );

   assign op   = instr[15:12];
   assign rd   = instr[11:9];
   assign rs1  = instr[8:6];
   assign rs2  = instr[5:3];
   assign off6 = {2'b00, instr[5:0]};

   cpu_reg_file reg_file (
      .clk   (clk),
      .rst   (rst),
      .we    (reg_we),
      .waddr (rd),
      .wdata (wb_data),
      .ra1   (rs1),
      .ra2   (rs2),
      .ra3   (rd),
      .rd1   (a),
      .rd2   (b),
      .rd3   (rd_val)
   );

   // Store must not land while reset holds the core idle.
   cpu_data_mem data_mem (
      .clk   (clk),
      .we    (mem_write & ~rst),
      .addr  (alu_result),
      .wdata (rd_val),
      .rdata (mem_rdata)
   );

   always_comb begin
      alu_result = 8'd0;
      reg_we     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      wb_data    = 8'd0;
      pc_next    = pc + 16'd1;
      case (op)
         4'b0000: begin alu_result = a + b;  reg_we = 1'b1; end
         4'b0001: begin alu_result = a - b;  reg_we = 1'b1; end
         4'b0010: begin alu_result = a & b;  reg_we = 1'b1; end
         4'b0011: begin alu_result = a | b;  reg_we = 1'b1; end
         4'b0100: begin alu_result = a ^ b;  reg_we = 1'b1; end
         4'b0101: begin alu_result = ~a;     reg_we = 1'b1; end
         4'b0110: begin alu_result = instr[7:0]; reg_we = 1'b1; end
         4'b0111: begin alu_result = a + off6; mem_read = 1'b1; reg_we = 1'b1; end
         4'b1000: begin alu_result = a + off6; mem_write = 1'b1; end
         4'b1001: begin alu_result = a + off6; reg_we = 1'b1; end
         4'b1011: pc_next = {4'b0000, instr[11:0]};
         4'b1111: begin
            alu_result = a - b;
            if (alu_result == 8'd0) pc_next = pc + 16'd1 + {8'd0, off6};
         end
         default: ;
      endcase
      wb_data = mem_read ? mem_rdata : alu_result;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= 16'd0;
      else     pc <= pc_next;
   end

   assign pc_out              = pc;
   assign current_instruction = instr;
   assign alu_result_out      = alu_result;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: preloads programs hierarchically, steps the clock
// and checks PC, registers, data memory and decode strobes against hand values.

module tb_cpu;
   logic        clk;
   logic        rst;
   logic [15:0] pc_out;
   logic [15:0] current_instruction;
   logic [7:0]  alu_result_out;

   int checks = 0;
   int errors = 0;

   cpu dut (
      .clk                 (clk),
      .rst                 (rst),
      .pc_out              (pc_out),
      .current_instruction (current_instruction),
      .alu_result_out      (alu_result_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs_zero(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_r%0d", tag, i), {24'd0, dut.reg_file.register_tab[i]}, 32'd0);
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      for (int i = 0; i < 256; i++) dut.prog_mem.memory[i] = 16'hA000;
      dut.prog_mem.memory[0] = 16'h620A; // LDI R1,10
      dut.prog_mem.memory[1] = 16'h6405; // LDI R2,5
      dut.prog_mem.memory[2] = 16'h0650; // ADD R3,R1,R2
      dut.prog_mem.memory[3] = 16'h2850; // AND R4,R1,R2
      dut.prog_mem.memory[4] = 16'h8610; // ST  R3,[R0+16]
      dut.prog_mem.memory[5] = 16'h7E10; // LD  R7,[R0+16]
      dut.prog_mem.memory[6] = 16'hF050; // BEQ R1,R2 (offset field overlaps rs2)
      dut.prog_mem.memory[7] = 16'hB002; // JMP 2

      #1;
      check("rst_pc", {16'd0, pc_out}, 32'd0);
      check_regs_zero("rst");
      check("rst_instr", {16'd0, current_instruction}, 32'h620A);
      #19;
      rst = 1'b0;
      #2;
      check("ldi_alu", {24'd0, alu_result_out}, 32'd10);

      step();
      check("pc1", {16'd0, pc_out}, 32'd1);
      check("r1", {24'd0, dut.reg_file.register_tab[1]}, 32'd10);
      step();
      check("pc2", {16'd0, pc_out}, 32'd2);
      check("r2", {24'd0, dut.reg_file.register_tab[2]}, 32'd5);
      check("add_alu", {24'd0, alu_result_out}, 32'd15);
      step();
      check("r3", {24'd0, dut.reg_file.register_tab[3]}, 32'd15);
      step();
      check("r4_and", {24'd0, dut.reg_file.register_tab[4]}, 32'd0);
      check("st_wr", {31'd0, dut.mem_write}, 32'd1);
      check("st_rd", {31'd0, dut.mem_read}, 32'd0);
      check("st_addr", {24'd0, dut.alu_result}, 32'd16);
      step();
      check("mem16", {24'd0, dut.data_mem.mem[16]}, 32'd15);
      check("ld_rd", {31'd0, dut.mem_read}, 32'd1);
      check("ld_wr", {31'd0, dut.mem_write}, 32'd0);
      step();
      check("r7_ld", {24'd0, dut.reg_file.register_tab[7]}, 32'd15);
      check("pc6", {16'd0, pc_out}, 32'd6);
      step();
      check("beq_not_taken", {16'd0, pc_out}, 32'd7);
      step();
      check("jmp", {16'd0, pc_out}, 32'd2);
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("loop_bound%0d", i), {31'd0, pc_out <= 16'd7}, 32'd1);
      end

      cnt = 0;
      while (pc_out != 16'd5 && cnt < 20) begin
         step();
         cnt++;
      end
      check("reach_pc5", {16'd0, pc_out}, 32'd5);
      rst = 1'b1;
      #1;
      check("midrst_pc", {16'd0, pc_out}, 32'd0);
      check_regs_zero("midrst");
      step();
      check("midrst_mem16", {24'd0, dut.data_mem.mem[16]}, 32'd15);

      dut.prog_mem.memory[0] = 16'h620A; // LDI R1,10
      dut.prog_mem.memory[1] = 16'h6405; // LDI R2,5
      dut.prog_mem.memory[2] = 16'h1A88; // SUB R5,R2,R1
      dut.prog_mem.memory[3] = 16'h60FF; // LDI R0,255
      dut.prog_mem.memory[4] = 16'h0000; // ADD R0,R0,R0
      dut.prog_mem.memory[5] = 16'hA000; // NOP
      dut.prog_mem.memory[6] = 16'hF003; // BEQ R0,R0,+3
      dut.prog_mem.memory[7] = 16'hA000;
      #1;
      check("rst2_instr", {16'd0, current_instruction}, 32'h620A);
      @(negedge clk);
      rst = 1'b0;
      #1;
      step();
      step();
      check("sub_alu", {24'd0, alu_result_out}, 32'd251);
      step();
      check("r5_sub", {24'd0, dut.reg_file.register_tab[5]}, 32'd251);
      step();
      check("r0_ldi", {24'd0, dut.reg_file.register_tab[0]}, 32'd255);
      step();
      check("r0_wrap", {24'd0, dut.reg_file.register_tab[0]}, 32'd254);
      step();
      check("pc6b", {16'd0, pc_out}, 32'd6);
      step();
      check("beq_taken", {16'd0, pc_out}, 32'd10);
      step();
      check("pc11", {16'd0, pc_out}, 32'd11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
